// File: rtl/tapasco_dmi_bridge_if.sv
// DMI request/response types and the per-channel DMI bus bundle between
// the host bridge (master) and the debug modules (slave).
package tapasco_dmi_bridge_pkg;
  localparam logic [1:0] DTM_NOP   = 2'h0;
  localparam logic [1:0] DTM_READ  = 2'h1;
  localparam logic [1:0] DTM_WRITE = 2'h2;

  typedef struct packed {
    logic [6:0]  addr;
    logic [1:0]  op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;
endpackage

// NR_CHANNELS must match the bridge instance it is connected to.
interface tapasco_dmi_bridge_if #(
  parameter int NR_CHANNELS = 1
);
  import tapasco_dmi_bridge_pkg::*;

  logic [NR_CHANNELS-1:0]                req_valid;
  logic [NR_CHANNELS-1:0]                req_ready;
  dmi_req_t                              req;
  logic [NR_CHANNELS-1:0]                resp_valid;
  logic [NR_CHANNELS-1:0]                resp_ready;
  dmi_resp_t [NR_CHANNELS-1:0]           resp;

  modport master (
    output req_valid, req, resp_ready,
    input  req_ready, resp_valid, resp
  );

  modport slave (
    input  req_valid, req, resp_ready,
    output req_ready, resp_valid, resp
  );
endinterface

// File: rtl/tapasco_dmi_bridge.sv
// Host level-signalled register port to multi-channel DMI bridge.
// One DMI transaction per rising edge of host_req_i, with channel select,
// response timeout and draining of stale responses on idle channels.
module tapasco_dmi_bridge
  import tapasco_dmi_bridge_pkg::*;
#(
  parameter int NR_CHANNELS    = 1,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int SEL_WIDTH      = (NR_CHANNELS > 1) ? $clog2(NR_CHANNELS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 host_req_i,
  input  logic                 host_wr_i,
  input  logic [SEL_WIDTH-1:0] host_sel_i,
  input  logic [6:0]           host_addr_i,
  input  logic [31:0]          host_wdata_i,
  output logic [31:0]          host_rdata_o,
  output logic [1:0]           host_resp_o,
  output logic                 host_timeout_o,
  output logic                 host_busy_o,
  output logic                 host_done_o,
  output logic                 host_overrun_o,
  tapasco_dmi_bridge_if.master dmi
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  logic [1:0]             r_state;
  logic                   r_req_q;
  logic                   r_wr;
  logic [SEL_WIDTH-1:0]   r_sel;
  logic [6:0]             r_addr;
  logic [31:0]            r_wdata;
  logic [31:0]            r_cnt;
  logic [31:0]            r_rdata;
  logic [1:0]             r_resp;
  logic                   r_timeout;
  logic                   r_done;
  logic                   r_overrun;
  logic [NR_CHANNELS-1:0] r_req_valid;
  logic [NR_CHANNELS-1:0] r_resp_ready;
  logic [1:0]             r_out_op;

  logic                   w_rise;
  logic                   w_sel_ok;
  logic                   w_accept;
  logic                   w_req_hs;
  logic                   w_resp_hs;
  logic                   w_expire;
  logic [1:0]             w_next_state;
  logic [SEL_WIDTH-1:0]   w_next_sel;
  logic [NR_CHANNELS-1:0] w_sel_mask;
  logic [NR_CHANNELS-1:0] w_next_mask;
  logic [33:0]            w_resp_sel;
  dmi_resp_t              w_resp;

  assign w_rise    = host_req_i & ~r_req_q;
  assign w_sel_ok  = (32'(host_sel_i) < 32'(NR_CHANNELS));
  assign w_accept  = (r_state == S_IDLE) & w_rise & w_sel_ok;
  assign w_req_hs  = |(r_req_valid & dmi.req_ready);
  assign w_resp_hs = (r_state == S_RESP) & (|(w_sel_mask & dmi.resp_valid));
  assign w_expire  = TO_EN & (r_state != S_IDLE) & (r_cnt >= TO_LAST);
  assign w_next_sel = w_accept ? host_sel_i : r_sel;
  assign w_resp    = dmi_resp_t'(w_resp_sel);

  // One-hot decode of the latched and next channel, and response mux of the latched channel.
  always_comb begin
    w_sel_mask  = '0;
    w_next_mask = '0;
    w_resp_sel  = '0;
    for (int c = 0; c < NR_CHANNELS; c++) begin
      w_sel_mask[c]  = (SEL_WIDTH'(c) == r_sel);
      w_next_mask[c] = (SEL_WIDTH'(c) == w_next_sel);
      w_resp_sel     = w_resp_sel | ({34{w_sel_mask[c]}} & 34'(dmi.resp[c]));
    end
  end

  // Next-state logic; a completing handshake always wins over timeout expiry.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next_state = S_REQ;
        else          w_next_state = S_IDLE;
      end
      S_REQ: begin
        if (w_req_hs)      w_next_state = S_RESP;
        else if (w_expire) w_next_state = S_IDLE;
        else               w_next_state = S_REQ;
      end
      S_RESP: begin
        if (w_resp_hs || w_expire) w_next_state = S_IDLE;
        else                       w_next_state = S_RESP;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State, latched request, host result registers and registered DMI handshake outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_req_q      <= 1'b1;
      r_wr         <= 1'b0;
      r_sel        <= '0;
      r_addr       <= 7'd0;
      r_wdata      <= 32'd0;
      r_cnt        <= 32'd0;
      r_rdata      <= 32'd0;
      r_resp       <= 2'b00;
      r_timeout    <= 1'b0;
      r_done       <= 1'b0;
      r_overrun    <= 1'b0;
      r_req_valid  <= '0;
      r_resp_ready <= '0;
      r_out_op     <= DTM_NOP;
    end else begin
      r_req_q      <= host_req_i;
      r_state      <= w_next_state;
      r_done       <= 1'b0;
      // The selected channel's response ready is held low only while its request is pending.
      r_req_valid  <= (w_next_state == S_REQ) ? w_next_mask : '0;
      r_resp_ready <= (w_next_state == S_REQ) ? ~w_next_mask : '1;
      r_out_op     <= (w_next_state == S_REQ) ? (w_accept ? (host_wr_i ? DTM_WRITE : DTM_READ)
                                                          : r_out_op)
                                              : DTM_NOP;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_wr      <= host_wr_i;
            r_sel     <= host_sel_i;
            r_addr    <= host_addr_i;
            r_wdata   <= host_wdata_i;
            r_overrun <= 1'b0;
            r_cnt     <= 32'd0;
          end else if (w_rise) begin
            r_resp    <= 2'b10;
            r_timeout <= 1'b0;
            r_done    <= 1'b1;
          end else begin
            r_cnt     <= r_cnt;
          end
        end
        S_REQ, S_RESP: begin
          r_cnt <= r_cnt + 32'd1;
          if (w_rise) r_overrun <= 1'b1;
          else        r_overrun <= r_overrun;
          if (w_resp_hs) begin
            r_rdata   <= w_resp.data;
            r_resp    <= w_resp.resp;
            r_timeout <= 1'b0;
            r_done    <= 1'b1;
          end else if (w_expire && !w_req_hs) begin
            r_resp    <= 2'b10;
            r_timeout <= 1'b1;
            r_done    <= 1'b1;
          end else begin
            r_resp    <= r_resp;
          end
        end
        default: r_cnt <= 32'd0;
      endcase
    end
  end

  assign host_rdata_o   = r_rdata;
  assign host_resp_o    = r_resp;
  assign host_timeout_o = r_timeout;
  assign host_busy_o    = (r_state != S_IDLE);
  assign host_done_o    = r_done;
  assign host_overrun_o = r_overrun;

  assign dmi.req_valid  = r_req_valid;
  assign dmi.resp_ready = r_resp_ready;
  assign dmi.req        = {r_addr, r_out_op, r_wdata};

  logic w_unused;
  assign w_unused = r_wr;

endmodule
